axi_lite_cmd_master: RTL

// - Command-driven AXI4-Lite initiator: the other end of the s_axi_lite register port.
// - Turns one write/read command into a single AXI4-Lite transaction.
// - Returns the slave response (and read data) on a response channel.
// - Lets benches and on-chip sequencers program the register map without a CPU.

---
 rtl/axi_lite_cmd_master.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_cmd_master.sv
// Command-driven AXI4-Lite initiator: each accepted command becomes exactly one
// AXI4-Lite read or write, and the slave's answer comes back on the response channel.
module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [COUNT_WIDTH-1:0]    txn_count,

    output logic [ADDR_WIDTH-1:0]     m_axi_lite_awaddr,
    output logic [2:0]                m_axi_lite_awprot,
    output logic                      m_axi_lite_awvalid,
    input  logic                      m_axi_lite_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_lite_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_lite_wstrb,
    output logic                      m_axi_lite_wvalid,
    input  logic                      m_axi_lite_wready,
    input  logic [1:0]                m_axi_lite_bresp,
    input  logic                      m_axi_lite_bvalid,
    output logic                      m_axi_lite_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_lite_araddr,
    output logic [2:0]                m_axi_lite_arprot,
    output logic                      m_axi_lite_arvalid,
    input  logic                      m_axi_lite_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_lite_rdata,
    input  logic [1:0]                m_axi_lite_rresp,
    input  logic                      m_axi_lite_rvalid,
    output logic                      m_axi_lite_rready,

    output logic [2:0]                dbg_state
);

    // Every channel uses the same rule: a transfer happens on the rising clock
    // edge where valid and ready are both high; a raised valid is held, with its
    // payload unchanged, until that edge, and never waits on the matching ready.

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WR_B = 3'd2,
        RD_A = 3'd3,
        RD_R = 3'd4,
        RSP  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;

    logic cmd_fire;
    logic b_fire;
    logic r_fire;
    logic rsp_fire;
    logic aw_clear;
    logic w_clear;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign b_fire   = m_axi_lite_bvalid & m_axi_lite_bready;
    assign r_fire   = m_axi_lite_rvalid & m_axi_lite_rready;
    assign rsp_fire = rsp_valid & rsp_ready;

    // A channel counts as done once its valid has dropped or it handshakes this cycle.
    assign aw_clear = ~m_axi_lite_awvalid | m_axi_lite_awready;
    assign w_clear  = ~m_axi_lite_wvalid  | m_axi_lite_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        m_axi_lite_bready  = 1'b0;
        m_axi_lite_arvalid = 1'b0;
        m_axi_lite_rready  = 1'b0;
        rsp_valid          = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_nxt = cmd_write ? WR : RD_A;
                end
            end
            WR: begin
                if (aw_clear && w_clear) begin
                    state_nxt = WR_B;
                end
            end
            WR_B: begin
                m_axi_lite_bready = 1'b1;
                if (m_axi_lite_bvalid) begin
                    state_nxt = RSP;
                end
            end
            RD_A: begin
                m_axi_lite_arvalid = 1'b1;
                if (m_axi_lite_arready) begin
                    state_nxt = RD_R;
                end
            end
            RD_R: begin
                m_axi_lite_rready = 1'b1;
                if (m_axi_lite_rvalid) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // cmd_ready is registered so it stays low throughout reset and the cycle it is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready          <= 1'b0;
            addr_q             <= '0;
            wdata_q            <= '0;
            wstrb_q            <= '0;
            m_axi_lite_awvalid <= 1'b0;
            m_axi_lite_wvalid  <= 1'b0;
            rsp_write          <= 1'b0;
            rsp_rdata          <= '0;
            rsp_resp           <= 2'b00;
            txn_count          <= '0;
        end else begin
            cmd_ready <= (state_nxt == IDLE);
            if (cmd_fire) begin
                addr_q             <= cmd_addr;
                wdata_q            <= cmd_wdata;
                wstrb_q            <= cmd_wstrb;
                m_axi_lite_awvalid <= cmd_write;
                m_axi_lite_wvalid  <= cmd_write;
            end else begin
                if (m_axi_lite_awvalid && m_axi_lite_awready) begin
                    m_axi_lite_awvalid <= 1'b0;
                end
                if (m_axi_lite_wvalid && m_axi_lite_wready) begin
                    m_axi_lite_wvalid <= 1'b0;
                end
            end
            if (b_fire) begin
                rsp_write <= 1'b1;
                rsp_rdata <= '0;
                rsp_resp  <= m_axi_lite_bresp;
            end
            if (r_fire) begin
                rsp_write <= 1'b0;
                rsp_rdata <= m_axi_lite_rdata;
                rsp_resp  <= m_axi_lite_rresp;
            end
            if (rsp_fire) begin
                txn_count <= txn_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign m_axi_lite_awaddr = addr_q;
    assign m_axi_lite_awprot = 3'b000;
    assign m_axi_lite_wdata  = wdata_q;
    assign m_axi_lite_wstrb  = wstrb_q;
    assign m_axi_lite_araddr = addr_q;
    assign m_axi_lite_arprot = 3'b000;
    assign dbg_state         = state;

endmodule
